// File: rtl/arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port indices, bus width.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LD  = 1'b1;

    localparam int DATA_W = 32;

endpackage

// File: rtl/arb_pick.sv
// Two-way winner select: a lone request wins outright; on a tie the port other than ptr wins.
// Purely combinational, no backpressure of its own.
module arb_pick
    import arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic vld,
    output logic idx
);

    assign vld = req0 | req1;
    assign idx = (req0 & req1) ? ~ptr : (req1 ? PORT_LD : PORT_CPU);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter (cpu / loader) in front of a single-ported data memory; ARB_ROUND_ROBIN_EN selects round-robin ties.
// Latency: gnt in the cycle after the request is sampled, rvalid one cycle after gnt.
// Backpressure: requesters hold req until gnt; one access per cycle alternating, every second cycle for one port.
module dmem_arbiter
    import arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,

    input  logic              req0,
    input  logic              we0,
    input  logic [DATA_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [DATA_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,

    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t            state;
    state_t            stateNxt;
    logic              winIdx;
    logic              cmdWe;
    logic [DATA_W-1:0] cmdAddr;
    logic [DATA_W-1:0] cmdWdata;
    logic              req0Masked;
    logic              req1Masked;
    logic              pickVld;
    logic              pickIdx;
    logic              ptr;

`ifdef ARB_ROUND_ROBIN_EN
    logic lastWin;

    always_ff @(posedge clk) begin
        if (reset) begin
            lastWin <= PORT_LD;
        end else if (pickVld) begin
            lastWin <= pickIdx;
        end
    end

    assign ptr = lastWin;
`else
    // Pointer pinned to the loader port makes every tie go to the cpu port.
    assign ptr = PORT_LD;
`endif

    arb_pick uPick (
        .req0 (req0Masked),
        .req1 (req1Masked),
        .ptr  (ptr),
        .vld  (pickVld),
        .idx  (pickIdx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    always_comb begin
        stateNxt   = IDLE;
        req0Masked = req0;
        req1Masked = req1;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        busy       = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                stateNxt = pickVld ? SERVE : IDLE;
            end
            SERVE: begin
                // The port being granted still shows its old request this cycle.
                req0Masked = req0 & (winIdx != PORT_CPU);
                req1Masked = req1 & (winIdx != PORT_LD);
                stateNxt   = pickVld ? SERVE : IDLE;
                gnt0       = (winIdx == PORT_CPU);
                gnt1       = (winIdx == PORT_LD);
                busy       = 1'b1;
                mem_we     = cmdWe & ~reset;
                mem_addr   = cmdAddr;
                mem_wdata  = cmdWdata;
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            winIdx   <= PORT_CPU;
            cmdWe    <= 1'b0;
            cmdAddr  <= '0;
            cmdWdata <= '0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            if (state == SERVE && !cmdWe) begin
                if (winIdx == PORT_CPU) begin
                    rvalid0 <= 1'b1;
                    rdata0  <= mem_rdata;
                end else begin
                    rvalid1 <= 1'b1;
                    rdata1  <= mem_rdata;
                end
            end
            if (pickVld) begin
                winIdx   <= pickIdx;
                cmdWe    <= (pickIdx == PORT_LD) ? we1    : we0;
                cmdAddr  <= (pickIdx == PORT_LD) ? addr1  : addr0;
                cmdWdata <= (pickIdx == PORT_LD) ? wdata1 : wdata0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a transaction-level arbitration and memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .gnt0      (gnt0),
        .rvalid0   (rvalid0),
        .rdata0    (rdata0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .gnt1      (gnt1),
        .rvalid1   (rvalid1),
        .rdata1    (rdata1),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // Memory behind the arbiter, written only through the DUT's memory port.
    logic [31:0] mem [256];
    assign mem_rdata = mem[mem_addr[9:2]];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
        forever begin
            @(posedge clk);
            if (mem_we === 1'b1) mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    cmd_t        q0[$];
    cmd_t        q1[$];
    cmd_t        cur[2];
    bit          pend[2];

    // Reference model: expected grant/rvalid in the coming cycle, golden memory.
    int          mGnt;
    int          mRv;
    int          mLast;
    cmd_t        mCmd;
    logic [31:0] expRd[2];
    logic [31:0] gold[256];

    int checks = 0;
    int errors = 0;

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        cmd_t c;
        c.we = we;
        c.addr = addr;
        c.wdata = wdata;
        if (p == 0) q0.push_back(c);
        else q1.push_back(c);
    endtask

    // One clock cycle: check outputs, let requesters react, then advance the model over the next edge.
    task automatic step(input bit rst);
        int w;
        bit c0, c1;
        @(negedge clk);
        checkVal("gnt", {30'd0, gnt1, gnt0}, {30'd0, mGnt == 1, mGnt == 0});
        checkVal("busy", {31'd0, busy}, {31'd0, mGnt >= 0});
        checkVal("rvalid", {30'd0, rvalid1, rvalid0}, {30'd0, mRv == 1, mRv == 0});
        checkVal("rdata0", rdata0, expRd[0]);
        checkVal("rdata1", rdata1, expRd[1]);
        checkVal("mem_addr", mem_addr, (mGnt >= 0) ? mCmd.addr : 32'd0);
        checkVal("mem_wdata", mem_wdata, (mGnt >= 0) ? mCmd.wdata : 32'd0);

        for (int p = 0; p < 2; p++)
            if (pend[p] && mGnt == p) pend[p] = 1'b0;
        if (!pend[0] && q0.size() > 0) begin cur[0] = q0.pop_front(); pend[0] = 1'b1; end
        if (!pend[1] && q1.size() > 0) begin cur[1] = q1.pop_front(); pend[1] = 1'b1; end
        reset  = rst;
        req0   = pend[0];
        we0    = cur[0].we;
        addr0  = cur[0].addr;
        wdata0 = cur[0].wdata;
        req1   = pend[1];
        we1    = cur[1].we;
        addr1  = cur[1].addr;
        wdata1 = cur[1].wdata;
        #1;
        checkVal("mem_we", {31'd0, mem_we}, {31'd0, (mGnt >= 0) && mCmd.we && !rst});

        if (rst) begin
            mGnt  = -1;
            mRv   = -1;
            mLast = 1;
            expRd[0] = 32'd0;
            expRd[1] = 32'd0;
        end else begin
            mRv = -1;
            if (mGnt >= 0) begin
                if (mCmd.we) begin
                    gold[mCmd.addr[9:2]] = mCmd.wdata;
                end else begin
                    mRv = mGnt;
                    expRd[mGnt] = gold[mCmd.addr[9:2]];
                end
            end
            c0 = pend[0] && (mGnt != 0);
            c1 = pend[1] && (mGnt != 1);
            if (c0 && c1) w = (RR && mLast == 0) ? 1 : 0;
            else if (c0) w = 0;
            else if (c1) w = 1;
            else w = -1;
            if (w >= 0) begin
                mLast = w;
                mCmd  = cur[w];
            end
            mGnt = w;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) gold[i] = 32'hA500_0000 | i;
        reset = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        mGnt = -1; mRv = -1; mLast = 1; mCmd = '0;
        expRd[0] = '0; expRd[1] = '0;
        cur[0] = '0; cur[1] = '0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        repeat (2) @(posedge clk);

        // Request held through reset must wait for the first edge with reset low.
        push(1, 1'b0, 32'h30, 32'h0);
        step(1'b1);
        step(1'b1);
        run(4);

        // Write then read back on the cpu port.
        push(0, 1'b1, 32'h40, 32'hDEADBEEF);
        run(4);
        push(0, 1'b0, 32'h40, 32'h0);
        run(4);
        checkVal("rd0_beef", rdata0, 32'hDEADBEEF);

        // Simultaneous reads from both ports.
        push(0, 1'b0, 32'h10, 32'h0);
        push(1, 1'b0, 32'h20, 32'h0);
        run(5);
        checkVal("rd0_10", rdata0, 32'hA500_0004);
        checkVal("rd1_20", rdata1, 32'hA500_0008);

        // Both ports saturating: grants must alternate with no idle cycle.
        for (int i = 0; i < 3; i++) begin
            push(0, 1'b0, 32'h50 + 4 * i, 32'h0);
            push(1, 1'b0, 32'h60 + 4 * i, 32'h0);
        end
        run(10);

        // Loader port alone, three back-to-back reads.
        for (int i = 0; i < 3; i++) push(1, 1'b0, 32'h20 + 4 * i, 32'h0);
        run(8);

        // Reset landing in the serve cycle of a write.
        push(0, 1'b1, 32'h80, 32'h55);
        step(1'b0);
        step(1'b1);
        step(1'b0);
        run(2);
        checkVal("mem80_kept", mem[32], 32'hA500_0020);

        // Same-address writes from both ports in one cycle.
        push(0, 1'b1, 32'h84, 32'h11);
        push(1, 1'b1, 32'h84, 32'h22);
        run(5);
        checkVal("same_addr", mem[33], gold[33]);

        // Random traffic with sparse resets.
        for (int i = 0; i < 600; i++) begin
            if (q0.size() < 2 && $urandom_range(0, 2) == 0)
                push(0, 1'($urandom_range(0, 1)), {24'd0, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
            if (q1.size() < 2 && $urandom_range(0, 2) == 0)
                push(1, 1'($urandom_range(0, 1)), {24'd0, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
            step($urandom_range(0, 99) == 0);
        end
        run(12);

        for (int i = 0; i < 64; i++) checkVal("mem_final", mem[i], gold[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
